// File: rtl/rv_pkg.sv
// Shared RV32IM pipeline types: ID/EX and EX/MEM register layouts, ALU opcodes
// and the EX-stage iterative-unit state encoding.
package rv_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_LUI, ALU_AUIPC, ALU_LINK,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;

  typedef enum logic [1:0] {
    EX_IDLE,
    EX_BUSY,
    EX_DONE
  } ex_state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
  } mem_ctrl_reg_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_reg_t;

  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   read_data1;
    logic [31:0]   read_data2;
    logic [31:0]   imm;
    logic [4:0]    inst_rd;
    alu_op_t       alu_op;
    logic          alu_src_imm;
    mem_ctrl_reg_t mem_ctrl;
    wb_ctrl_reg_t  wb_ctrl;
  } id_ex_regs_t;

  typedef struct packed {
    logic [31:0]   alu_out;
    logic [31:0]   read_data2;
    logic [4:0]    inst_rd;
    mem_ctrl_reg_t mem_ctrl;
    wb_ctrl_reg_t  wb_ctrl;
  } ex_mem_regs_t;

  function automatic logic is_m_op(input alu_op_t op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative M-extension unit: 32-step shift-add multiplier / restoring divider
// working on operand magnitudes, with sign correction applied in DONE.
module muldiv_iter
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  input  logic        start,
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  ex_state_t   state, state_next;
  logic [4:0]  count;
  logic [63:0] acc;
  logic [31:0] divisor;
  alu_op_t     op_q;
  logic        neg_q, neg_r;

  logic        a_signed, b_signed, a_neg, b_neg, start_div, run_div;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift;
  logic        div_ok;
  logic [63:0] acc_step, prod;
  logic [31:0] quo, rem;

  always_comb begin
    a_signed  = op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    b_signed  = op inside {ALU_MULH, ALU_DIV, ALU_REM};
    start_div = op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    a_neg     = a_signed & a[31];
    b_neg     = b_signed & b[31];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  // acc: multiply = {partial high, remaining multiplier}; divide = {remainder, quotient}
  always_comb begin
    run_div   = op_q inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, divisor} : 33'd0);
    div_shift = {acc[63:32], acc[31]};
    div_ok    = div_shift >= {1'b0, divisor};
    if (run_div)
      acc_step = div_ok ? {div_shift[31:0] - divisor, acc[30:0], 1'b1}
                        : {div_shift[31:0], acc[30:0], 1'b0};
    else
      acc_step = {mul_sum, acc[31:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EX_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      EX_IDLE: if (start) state_next = EX_BUSY;
      EX_BUSY: if (count == 5'd31) state_next = EX_DONE;
      EX_DONE: state_next = EX_IDLE;
      default: state_next = EX_IDLE;
    endcase
    if (abort) state_next = EX_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      acc     <= '0;
      divisor <= '0;
      op_q    <= ALU_MUL;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (state == EX_IDLE && start) begin
      count   <= '0;
      acc     <= {32'd0, a_mag};
      divisor <= b_mag;
      op_q    <= op;
      // Division by zero keeps the all-ones quotient unsigned-looking
      neg_q   <= start_div ? ((a_neg ^ b_neg) && (b != 32'd0)) : (a_neg ^ b_neg);
      neg_r   <= a_neg;
    end else if (state == EX_BUSY) begin
      acc   <= acc_step;
      count <= count + 5'd1;
    end
  end

  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[31:0] : acc[31:0];
    rem  = neg_r ? -acc[63:32] : acc[63:32];
    unique case (op_q)
      ALU_MUL:                        result = prod[31:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: result = prod[63:32];
      ALU_DIV, ALU_DIVU:              result = quo;
      default:                        result = rem;
    endcase
  end

  assign busy = (state == EX_BUSY);
  assign done = (state == EX_DONE);

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: single-cycle ALU for RV32I ops, iterative M-op unit
// with upstream stall, and the EX/MEM pipeline register.
module ex_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic         i_flush,
  input  id_ex_regs_t  i_id_ex_regs,
  output logic         o_stall,
  output logic         o_ex_valid,
  output ex_mem_regs_t o_ex_mem_regs
);

  logic [XLEN-1:0] op_a, op_b, alu_res;
  logic [4:0]      shamt;
  logic            md_start, md_busy, md_done;
  logic [31:0]     md_result;

  always_comb begin
    op_a    = i_id_ex_regs.read_data1;
    op_b    = i_id_ex_regs.alu_src_imm ? i_id_ex_regs.imm : i_id_ex_regs.read_data2;
    shamt   = op_b[4:0];
    alu_res = '0;
    unique case (i_id_ex_regs.alu_op)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_SLL:   alu_res = op_a << shamt;
      ALU_SLT:   alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_res = {31'd0, op_a < op_b};
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SRL:   alu_res = op_a >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:    alu_res = op_a | op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_LUI:   alu_res = op_b;
      ALU_AUIPC: alu_res = i_id_ex_regs.pc + op_b;
      ALU_LINK:  alu_res = i_id_ex_regs.pc + 32'd4;
      default:   alu_res = '0;
    endcase
  end

  assign md_start = i_valid && is_m_op(i_id_ex_regs.alu_op) && !i_flush;

  muldiv_iter u_muldiv (
    .clk    (i_clk),
    .rst_n  (i_rst),
    .abort  (i_flush),
    .start  (md_start),
    .op     (i_id_ex_regs.alu_op),
    .a      (op_a),
    .b      (op_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // Stall is raised in the issuing cycle itself, before the unit leaves IDLE
  assign o_stall = md_busy || (md_start && !md_done);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_ex_valid    <= 1'b0;
      o_ex_mem_regs <= '0;
    end else if (i_flush || o_stall || !i_valid) begin
      o_ex_valid    <= 1'b0;
      o_ex_mem_regs <= '0;
    end else begin
      o_ex_valid               <= 1'b1;
      o_ex_mem_regs.alu_out    <= md_done ? md_result : alu_res;
      o_ex_mem_regs.read_data2 <= i_id_ex_regs.read_data2;
      o_ex_mem_regs.inst_rd    <= i_id_ex_regs.inst_rd;
      o_ex_mem_regs.mem_ctrl   <= i_id_ex_regs.mem_ctrl;
      o_ex_mem_regs.wb_ctrl    <= i_id_ex_regs.wb_ctrl;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: RV32I ops, M-op latency/results, flush and
// reset during an iterative op, store pass-through.
module tb_ex_stage;
  import rv_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid = 1'b0;
  logic         flush = 1'b0;
  id_ex_regs_t  id = '0;
  logic         stall, ex_valid;
  ex_mem_regs_t ex;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(32)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_valid       (valid),
    .i_flush       (flush),
    .i_id_ex_regs  (id),
    .o_stall       (stall),
    .o_ex_valid    (ex_valid),
    .o_ex_mem_regs (ex)
  );

  // Upstream must keep the instruction valid while the stage stalls
  always @(negedge clk)
    if (rst && stall && !flush)
      assert (valid) else $error("protocol: i_valid dropped while stalled");

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input alu_op_t op, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic src_imm);
    id.pc                 = pc;
    id.read_data1         = a;
    id.alu_op             = op;
    id.alu_src_imm        = src_imm;
    id.read_data2         = src_imm ? 32'h5555_5555 : b;
    id.imm                = src_imm ? b : 32'hAAAA_AAAA;
    id.inst_rd            = 5'd9;
    id.mem_ctrl           = '0;
    id.wb_ctrl.reg_write  = 1'b1;
    id.wb_ctrl.mem_to_reg = 1'b0;
    valid                 = 1'b1;
  endtask

  task automatic alu_step(input string tag, input alu_op_t op, input logic [31:0] pc,
                          input logic [31:0] a, input logic [31:0] b, input logic src_imm,
                          input logic [31:0] exp);
    drive(op, pc, a, b, src_imm);
    #1;
    check({tag, "_stall"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
    check(tag, ex.alu_out, exp);
    check({tag, "_valid"}, 32'(ex_valid), 32'd1);
    check({tag, "_rd"}, 32'(ex.inst_rd), 32'd9);
    $display("op %s: alu_out=0x%08h valid=%0d", tag, ex.alu_out, ex_valid);
    valid = 1'b0;
  endtask

  task automatic m_step(input string tag, input alu_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int stalls = 0;
    drive(op, 32'd0, a, b, 1'b0);
    #1;
    for (int c = 0; c < 40 && stall; c++) begin
      stalls++;
      @(posedge clk); #1;
    end
    check({tag, "_stalls"}, 32'(stalls), 32'd33);
    check({tag, "_done_bubble"}, 32'(ex_valid), 32'd0);
    @(posedge clk); #1;
    check(tag, ex.alu_out, exp);
    check({tag, "_valid"}, 32'(ex_valid), 32'd1);
    $display("mop %s: result=0x%08h stalls=%0d", tag, ex.alu_out, stalls);
    valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_alu_out", ex.alu_out, 32'd0);
    check("rst_rd2", ex.read_data2, 32'd0);
    check("rst_ctrl", 32'({ex.inst_rd, ex.mem_ctrl, ex.wb_ctrl}), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    alu_step("add_imm", ALU_ADD, 32'd0, 32'd5, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFFE);
    alu_step("sub", ALU_SUB, 32'd0, 32'd10, 32'd3, 1'b0, 32'd7);
    alu_step("sll31", ALU_SLL, 32'd0, 32'd1, 32'd31, 1'b0, 32'h8000_0000);
    alu_step("sll_mask", ALU_SLL, 32'd0, 32'd1, 32'h23, 1'b1, 32'd8);
    alu_step("slt", ALU_SLT, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1);
    alu_step("sltu", ALU_SLTU, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
    alu_step("sra", ALU_SRA, 32'd0, 32'h8000_0000, 32'd4, 1'b0, 32'hF800_0000);
    alu_step("srl", ALU_SRL, 32'd0, 32'h8000_0000, 32'd4, 1'b0, 32'h0800_0000);
    alu_step("xor", ALU_XOR, 32'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'h0FF0_0FF0);
    alu_step("and", ALU_AND, 32'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'hF000_F000);
    alu_step("or", ALU_OR, 32'd0, 32'hF0F0_F0F0, 32'h0000_000F, 1'b0, 32'hF0F0_F0FF);
    alu_step("lui", ALU_LUI, 32'd0, 32'h1234_5678, 32'h1234_5000, 1'b1, 32'h1234_5000);
    alu_step("auipc", ALU_AUIPC, 32'h100, 32'd0, 32'h1000, 1'b1, 32'h0000_1100);
    alu_step("link", ALU_LINK, 32'h200, 32'd0, 32'd0, 1'b1, 32'h0000_0204);

    m_step("mul", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    m_step("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    m_step("mulh", ALU_MULH, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF);
    m_step("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    m_step("div", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    m_step("rem", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    m_step("divu_by0", ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
    m_step("remu_by0", ALU_REMU, 32'd5, 32'd0, 32'd5);
    m_step("div_by0", ALU_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    m_step("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    m_step("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Flush in the middle of a divide
    drive(ALU_DIV, 32'd0, 32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("flush_busy_stall", 32'(stall), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    valid = 1'b0;
    #1;
    check("flush_stall", 32'(stall), 32'd0);
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_wb", 32'(ex.wb_ctrl), 32'd0);
    $display("flush: stall=%0d valid=%0d wb=%0d", stall, ex_valid, ex.wb_ctrl);
    alu_step("add_after_flush", ALU_ADD, 32'd0, 32'd20, 32'd22, 1'b0, 32'd42);

    // Reset asserted while the multiplier is busy
    drive(ALU_MUL, 32'd0, 32'd3, 32'd4, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("rst_busy_stall", 32'(stall), 32'd1);
    #2;
    rst   = 1'b0;
    valid = 1'b0;
    #1;
    check("rst_async_valid", 32'(ex_valid), 32'd0);
    check("rst_async_stall", 32'(stall), 32'd0);
    $display("reset in busy: stall=%0d valid=%0d", stall, ex_valid);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Store after reset: address rs1+imm, store data untouched
    drive(ALU_ADD, 32'd0, 32'h0000_1000, 32'h10, 1'b1);
    id.read_data2         = 32'hDEAD_BEEF;
    id.mem_ctrl.mem_write = 1'b1;
    id.mem_ctrl.funct3    = 3'b010;
    id.wb_ctrl.reg_write  = 1'b0;
    @(posedge clk); #1;
    check("sw_addr", ex.alu_out, 32'h0000_1010);
    check("sw_data", ex.read_data2, 32'hDEAD_BEEF);
    check("sw_mem_ctrl", 32'(ex.mem_ctrl), 32'(5'b01010));
    check("sw_wb", 32'(ex.wb_ctrl), 32'd0);
    check("sw_valid", 32'(ex_valid), 32'd1);
    $display("sw: addr=0x%08h data=0x%08h", ex.alu_out, ex.read_data2);
    valid = 1'b0;
    @(posedge clk); #1;
    check("idle_bubble_valid", 32'(ex_valid), 32'd0);
    check("idle_bubble_mem", 32'(ex.mem_ctrl), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
